// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block type, FSM state codes, rcon table and
// GF(2^8) arithmetic helpers used by both the encryption and decryption cores.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [2:0]   fsm_t;

    localparam fsm_t ST_IDLE   = 3'd0;
    localparam fsm_t ST_KEYEXP = 3'd1;
    localparam fsm_t ST_ADD0   = 3'd2;
    localparam fsm_t ST_ROUND  = 3'd3;
    localparam fsm_t ST_FINAL  = 3'd4;

    // Round constant for key-schedule group i (1..10); other indices give 0.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // General GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES byte substitution: 256-entry combinational map, forward (INVERSE=0)
// or inverse (INVERSE=1). The table is expressed as the defining GF(2^8)
// inverse plus affine transform, so both directions come from one source.
module aes_sbox
    import aes_pkg::*;
#(
    parameter logic INVERSE = 1'b0
) (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    // Multiplicative inverse as a^254 (zero maps to zero).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] a);
        return rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    endfunction

    if (INVERSE) begin : g_inv
        assign out_byte = gf_inv(affine_inv(in_byte));
    end else begin : g_fwd
        assign out_byte = affine_fwd(gf_inv(in_byte));
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher. The key register is first walked forward
// to round key 10, then stepped back one round per clock alongside the state.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         done,
    output logic         busy
);

    fsm_t         fsm;
    block_t       state_reg;
    block_t       key_reg;
    logic [3:0]   round_idx;   // rcon index going up, round number coming down

    block_t       shifted;
    block_t       subbed;
    logic [31:0]  ks_word;
    logic [31:0]  ks_rot;
    logic [31:0]  ks_sub;

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3);
            o[119 - 32 * c -: 8] = gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3);
            o[111 - 32 * c -: 8] = gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3);
            o[103 - 32 * c -: 8] = gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3);
        end
        return o;
    endfunction

    // Forward key step; sw is SubWord(RotWord(w3)) of the current round key.
    function automatic block_t key_fwd(input block_t k, input logic [31:0] sw, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sw ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Inverse key step; sw is SubWord(RotWord(w3 ^ w2)), i.e. of the previous w3.
    function automatic block_t key_inv(input block_t k, input logic [31:0] sw, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sw ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    assign shifted = inv_shift_rows(state_reg);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_sbox #(.INVERSE(1'b1)) u_sbox (
            .in_byte  (shifted[127 - 8 * i -: 8]),
            .out_byte (subbed[127 - 8 * i -: 8])
        );
    end

    // The four key-step S-boxes serve both directions; only their input differs.
    assign ks_word = (fsm == ST_KEYEXP) ? key_reg[31:0] : (key_reg[31:0] ^ key_reg[63:32]);
    assign ks_rot  = {ks_word[23:0], ks_word[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox #(.INVERSE(1'b0)) u_sbox (
            .in_byte  (ks_rot[31 - 8 * i -: 8]),
            .out_byte (ks_sub[31 - 8 * i -: 8])
        );
    end

    assign busy = (fsm != ST_IDLE) || done;

    // Control FSM, key schedule walk and round datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= ST_IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            round_idx <= 4'd0;
            plaintext <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ciphertext;
                        key_reg   <= key;
                        round_idx <= 4'd1;
                        fsm       <= ST_KEYEXP;
                    end
                end
                ST_KEYEXP: begin
                    key_reg <= key_fwd(key_reg, ks_sub, rcon(round_idx));
                    if (round_idx == 4'd10) begin
                        fsm <= ST_ADD0;
                    end else begin
                        round_idx <= round_idx + 4'd1;
                    end
                end
                ST_ADD0: begin
                    state_reg <= state_reg ^ key_reg;
                    key_reg   <= key_inv(key_reg, ks_sub, rcon(round_idx));
                    round_idx <= round_idx - 4'd1;
                    fsm       <= ST_ROUND;
                end
                ST_ROUND: begin
                    state_reg <= inv_mix_columns(subbed ^ key_reg);
                    key_reg   <= key_inv(key_reg, ks_sub, rcon(round_idx));
                    round_idx <= round_idx - 4'd1;
                    if (round_idx == 4'd1) fsm <= ST_FINAL;
                end
                ST_FINAL: begin
                    state_reg <= subbed ^ key_reg;
                    plaintext <= subbed ^ key_reg;
                    done      <= 1'b1;
                    fsm       <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: FIPS-197 vectors, protocol corner cases and
// random round-trips through a behavioural forward-cipher model.
module tb_aes_decrypt_core;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] key = '0;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] sb [0:255];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_decrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .plaintext  (plaintext),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then bitwise affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
            end
            sb[x] = s;
        end
    endtask

    // Textbook FIPS-197 forward cipher on a byte array.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [0:43];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = p[127 - 8 * b -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[4 * c + r] = t[4 * ((c + r) % 4) + r];
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                        s[4 * c]     = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                        s[4 * c + 1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                        s[4 * c + 2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                        s[4 * c + 3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4 * c + r] = s[4 * c + r] ^ w[4 * rnd + c][31 - 8 * r -: 8];
        end
        for (int b = 0; b < 16; b++) o[127 - 8 * b -: 8] = s[b];
        return o;
    endfunction

    // One start pulse, then wait (bounded) for done; lat counts edges after the start edge.
    task automatic run_block(input logic [127:0] k, input logic [127:0] c,
                             output logic [127:0] pt, output int lat);
        @(posedge clk); #1;
        key = k; ciphertext = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key = '0; ciphertext = '0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        pt = plaintext;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (plaintext !== 128'h0) begin failures++; $display("FAIL reset_plaintext got=%h want=0", plaintext); end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags got done=%b busy=%b want 0 0", done, busy); end
        checks++;
        if (dut.fsm !== ST_IDLE) begin failures++; $display("FAIL reset_fsm got=%0d want=%0d", dut.fsm, ST_IDLE); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_flags got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_fips_c1();
        logic [127:0] pt;
        int lat;
        run_block(C1_KEY, C1_CT, pt, lat);
        checks++;
        if (pt !== C1_PT) begin failures++; $display("FAIL c1_plaintext got=%h want=%h", pt, C1_PT); end
        checks++;
        if (lat != 21) begin failures++; $display("FAIL c1_latency got=%0d want=21", lat); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || plaintext !== C1_PT) begin
            failures++;
            $display("FAIL c1_after_done got done=%b busy=%b pt=%h want 0 0 %h", done, busy, plaintext, C1_PT);
        end
    endtask

    task automatic test_fips_b();
        int lat;
        logic seen_add0;
        logic [127:0] rk_seen;
        @(posedge clk); #1;
        key = B_KEY; ciphertext = B_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        seen_add0 = 1'b0;
        rk_seen = '0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (dut.fsm === ST_ADD0 && !seen_add0) begin
                seen_add0 = 1'b1;
                rk_seen = dut.key_reg;
            end
        end
        checks++;
        if (!seen_add0 || rk_seen !== B_RK10) begin
            failures++;
            $display("FAIL b_rk10_probe got seen=%b key=%h want %h", seen_add0, rk_seen, B_RK10);
        end
        checks++;
        if (plaintext !== B_PT || lat != 21) begin
            failures++;
            $display("FAIL b_plaintext got=%h lat=%0d want=%h lat=21", plaintext, lat, B_PT);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int ndone;
        int done_at;
        logic busy_ok;
        logic [127:0] pt;
        @(posedge clk); #1;
        key = C1_KEY; ciphertext = C1_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; done_at = -1; busy_ok = 1'b1; pt = '0;
        for (lat = 1; lat <= 45; lat++) begin
            if (lat == 5 || lat == 15) begin
                start = 1'b1;
                key = {$urandom, $urandom, $urandom, $urandom};
                ciphertext = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) begin done_at = lat; pt = plaintext; end
            end
            if (lat <= 21 && busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++;
        if (ndone != 1 || done_at != 21) begin failures++; $display("FAIL ignore_done_count got n=%0d at=%0d want n=1 at=21", ndone, done_at); end
        checks++;
        if (pt !== C1_PT) begin failures++; $display("FAIL ignore_plaintext got=%h want=%h", pt, C1_PT); end
        checks++;
        if (!busy_ok) begin failures++; $display("FAIL ignore_busy got=gap want=continuous"); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        int lat;
        int stale;
        @(posedge clk); #1;
        key = C1_KEY; ciphertext = C1_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (plaintext !== 128'h0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got pt=%h done=%b busy=%b want 0 0 0", plaintext, done, busy);
        end
        checks++;
        if (dut.fsm !== ST_IDLE) begin failures++; $display("FAIL midreset_fsm got=%0d want=%0d", dut.fsm, ST_IDLE); end
        #3 rst_n = 1'b1;
        stale = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL midreset_stale got=%0d want=0", stale); end
        run_block(B_KEY, B_CT, pt, lat);
        checks++;
        if (pt !== B_PT || lat != 21) begin failures++; $display("FAIL midreset_next got=%h lat=%0d want=%h lat=21", pt, lat, B_PT); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int d1;
        int d2;
        logic hold_ok;
        logic [127:0] p1;
        logic [127:0] p2;
        @(posedge clk); #1;
        key = C1_KEY; ciphertext = C1_CT; start = 1'b1;
        @(posedge clk); #1;
        key = B_KEY; ciphertext = B_CT;
        d1 = -1; d2 = -1; hold_ok = 1'b1; p1 = '0; p2 = '0;
        for (lat = 1; lat <= 60 && d2 < 0; lat++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (d1 < 0) begin d1 = lat; p1 = plaintext; end
                else begin d2 = lat; p2 = plaintext; start = 1'b0; end
            end else if (d1 >= 0 && plaintext !== C1_PT) begin
                hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (d1 != 21 || p1 !== C1_PT) begin failures++; $display("FAIL b2b_first got at=%0d pt=%h want at=21 pt=%h", d1, p1, C1_PT); end
        checks++;
        if (d2 - d1 != 22 || p2 !== B_PT) begin failures++; $display("FAIL b2b_second got gap=%0d pt=%h want gap=22 pt=%h", d2 - d1, p2, B_PT); end
        checks++;
        if (!hold_ok) begin failures++; $display("FAIL b2b_hold got=changed want=%h", C1_PT); end
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic test_round_trip();
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] c;
        logic [127:0] got;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin k = '0; p = '0; end
            else if (n == 1) begin k = '1; p = '1; end
            else begin
                k = {$urandom, $urandom, $urandom, $urandom};
                p = {$urandom, $urandom, $urandom, $urandom};
            end
            c = ref_encrypt(k, p);
            run_block(k, c, got, lat);
            checks++;
            if (got !== p || lat != 21) begin
                failures++;
                $display("FAIL roundtrip_%0d got=%h lat=%0d want=%h lat=21", n, got, lat, p);
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
